// File: rtl/pro3_cmd_sequencer.sv
// Command sequencer for the Pro_3 datapath: buffers LOAD/NOT/LOAD_NOT/READ commands in a FIFO,
// replays them as strobes, waits a settle interval and returns the sampled DO.
module pro3_cmd_sequencer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clka,
  input  logic       RESTART,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_OP,
  input  logic [3:0] CMD_DATA,
  output logic       LOAD,
  output logic       NOT,
  output logic [3:0] DATA,
  input  logic [3:0] DO,
  output logic       RES_VALID,
  input  logic       RES_READY,
  output logic [3:0] RES_DATA,
  output logic       BUSY
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = $clog2(SETTLE + 1);
  localparam logic [CNTW-1:0] FullCount = CNTW'(DEPTH);

  localparam logic [1:0] OpLoad    = 2'b00;
  localparam logic [1:0] OpNot     = 2'b01;
  localparam logic [1:0] OpLoadNot = 2'b10;

  typedef enum logic [2:0] {
    StIdle, StStrobe, StSettle, StStrobe2, StSettle2, StResult
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [3:0]      data_q, data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_dec;
  logic            res_valid_q, res_valid_d;
  logic [3:0]      res_data_q, res_data_d;

  // FIFO entries are {op, data}
  logic [5:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q;
  logic            full, empty, push, pop;
  logic [5:0]      head;

  assign full      = (count_q == FullCount);
  assign empty     = (count_q == '0);
  assign CMD_READY = !full && !RESTART;
  assign push      = CMD_VALID && CMD_READY;
  assign pop       = (state_q == StIdle) && !empty;
  assign head      = mem_q[rd_ptr_q];

  always_ff @(posedge clka) begin
    if (push) mem_q[wr_ptr_q] <= {CMD_OP, CMD_DATA};
  end

  always_ff @(posedge clka or posedge RESTART) begin
    if (RESTART) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clka or posedge RESTART) begin
    if (RESTART) begin
      state_q     <= StIdle;
      op_q        <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign cnt_dec = cnt_q - CW'(1);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          op_d    = head[5:4];
          state_d = StStrobe;
          // DATA only changes when a LOAD strobe is about to be driven
          if (head[5:4] == OpLoad || head[5:4] == OpLoadNot) data_d = head[3:0];
        end
      end
      StStrobe: begin
        state_d = StSettle;
        cnt_d   = CW'(SETTLE);
      end
      StSettle: begin
        cnt_d = cnt_dec;
        if (cnt_dec == '0) begin
          if (op_q == OpLoadNot) begin
            state_d = StStrobe2;
          end else begin
            state_d     = StResult;
            res_valid_d = 1'b1;
            res_data_d  = DO;
          end
        end
      end
      StStrobe2: begin
        state_d = StSettle2;
        cnt_d   = CW'(SETTLE);
      end
      StSettle2: begin
        cnt_d = cnt_dec;
        if (cnt_dec == '0) begin
          state_d     = StResult;
          res_valid_d = 1'b1;
          res_data_d  = DO;
        end
      end
      StResult: begin
        if (RES_READY) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign LOAD      = (state_q == StStrobe) && (op_q == OpLoad || op_q == OpLoadNot);
  assign NOT       = ((state_q == StStrobe) && (op_q == OpNot)) || (state_q == StStrobe2);
  assign DATA      = data_q;
  assign RES_VALID = res_valid_q;
  assign RES_DATA  = res_data_q;
  assign BUSY      = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_pro3_cmd_sequencer.sv
// Bench for pro3_cmd_sequencer: a 4-bit register models the datapath, and a command-level
// reference model predicts each result, checked in order against the result port.
module tb_pro3_cmd_sequencer;

  logic       clka = 1'b0;
  logic       restart;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic       load;
  logic       inv;
  logic [3:0] data;
  logic [3:0] dout;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       busy;

  pro3_cmd_sequencer #(.DEPTH(4), .SETTLE(2)) dut (
    .clka      (clka),
    .RESTART   (restart),
    .CMD_VALID (cmd_valid),
    .CMD_READY (cmd_ready),
    .CMD_OP    (cmd_op),
    .CMD_DATA  (cmd_data),
    .LOAD      (load),
    .NOT       (inv),
    .DATA      (data),
    .DO        (dout),
    .RES_VALID (res_valid),
    .RES_READY (res_ready),
    .RES_DATA  (res_data),
    .BUSY      (busy)
  );

  always #5 clka = ~clka;

  // Datapath register driven by the strobes
  logic [3:0] dp = 4'h0;
  always @(posedge clka) begin
    if (load) dp <= data;
    if (inv)  dp <= ~dp;
  end
  assign dout = dp;

  int vectors = 0;
  int miscompares = 0;
  int load_pulses = 0;
  int not_pulses = 0;
  int cyc = 0;
  logic prev_load = 1'b0;
  logic prev_inv = 1'b0;
  logic rand_ready = 1'b0;
  logic [3:0] ref_dp = 4'h0;
  logic [3:0] exp_q[$];
  logic [3:0] load_data_q[$];
  int         load_cyc_q[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Command-level semantics: what DO reads after the command completes
  function automatic logic [3:0] model(input logic [1:0] op, input logic [3:0] d);
    case (op)
      2'd0:    ref_dp = d;
      2'd1:    ref_dp = ~ref_dp;
      2'd2:    ref_dp = ~d;
      default: ref_dp = ref_dp;
    endcase
    return ref_dp;
  endfunction

  always @(negedge clka) begin
    if (restart) begin
      prev_load = 1'b0;
      prev_inv  = 1'b0;
    end else begin
      if (load || inv) check("strobe_overlap", 8'(load && inv), 8'h0);
      if (load) begin
        check("load_width", 8'(prev_load), 8'h0);
        load_pulses++;
        load_data_q.push_back(data);
        load_cyc_q.push_back(cyc);
      end
      if (inv) begin
        check("not_width", 8'(prev_inv), 8'h0);
        not_pulses++;
      end
      prev_load = load;
      prev_inv  = inv;
      if (res_valid && res_ready) begin
        check("res_expected", 8'(exp_q.size() != 0), 8'h1);
        if (exp_q.size() != 0) begin
          check("res_data", 8'(res_data), 8'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clka);
    #1;
    if (rand_ready) res_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] d);
    logic acc;
    acc = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    for (int i = 0; i < 200; i++) begin
      acc = cmd_ready;
      tick();
      if (acc) break;
    end
    cmd_valid = 1'b0;
    if (acc) exp_q.push_back(model(op, d));
    else check("send_timeout", 8'(acc), 8'h1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (!busy && !res_valid && exp_q.size() == 0) break;
      tick();
    end
    check("drain_busy", 8'(busy), 8'h0);
    check("drain_pending", 8'(exp_q.size()), 8'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lp0, np0;
    restart   = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_data  = 4'h0;
    res_ready = 1'b0;
    repeat (3) tick();
    check("rst_cmd_ready", 8'(cmd_ready), 8'h0);
    check("rst_outputs", {load, inv, res_valid, busy, data}, 8'h00);
    check("rst_res_data", 8'(res_data), 8'h0);
    restart = 1'b0;
    #1;
    check("post_rst_ready", 8'(cmd_ready), 8'h1);
    check("post_rst_busy", 8'(busy), 8'h0);

    // LOAD A with exact cycle timing
    res_ready = 1'b1;
    send(2'd0, 4'hA);
    check("e0_load", 8'(load), 8'h0);
    check("e0_busy", 8'(busy), 8'h1);
    tick();
    check("e1_load", 8'(load), 8'h1);
    check("e1_data", 8'(data), 8'hA);
    check("e1_not", 8'(inv), 8'h0);
    tick();
    check("e2_load", 8'(load), 8'h0);
    check("e2_data_hold", 8'(data), 8'hA);
    tick();
    check("e3_res_valid", 8'(res_valid), 8'h0);
    tick();
    check("e4_res_valid", 8'(res_valid), 8'h1);
    check("e4_res_data", 8'(res_data), 8'hA);
    tick();
    check("e5_res_valid", 8'(res_valid), 8'h0);
    check("e5_busy", 8'(busy), 8'h0);
    check("e5_res_hold", 8'(res_data), 8'hA);

    // NOT: one invert pulse, no load pulse
    lp0 = load_pulses;
    np0 = not_pulses;
    send(2'd1, 4'($urandom_range(0, 15)));
    drain();
    check("not_loads", 8'(load_pulses - lp0), 8'h0);
    check("not_nots", 8'(not_pulses - np0), 8'h1);
    check("not_result", 8'(res_data), 8'h5);

    // LOAD_NOT 3: load, two idle cycles, invert
    send(2'd2, 4'h3);
    tick();
    check("ln_e1_load", {3'b0, load, data}, 8'h13);
    tick();
    check("ln_e2_idle", {load, inv}, 8'h0);
    tick();
    check("ln_e3_idle", {load, inv}, 8'h0);
    tick();
    check("ln_e4_not", {load, inv}, 8'h1);
    drain();
    check("ln_result", 8'(res_data), 8'hC);

    // Backpressure: five commands, FIFO fills, results return in order
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    check("full_ready", 8'(cmd_ready), 8'h0);
    repeat (10) tick();
    check("held_valid", 8'(res_valid), 8'h1);
    check("held_full", 8'(cmd_ready), 8'h0);
    res_ready = 1'b1;
    drain();

    // Reset during settle with three commands queued
    for (int i = 0; i < 4; i++) send(2'd0, 4'($urandom_range(0, 15)));
    check("pre_rst_busy", 8'(busy), 8'h1);
    restart = 1'b1;
    #1;
    check("mid_rst_outputs", {load, inv, res_valid, busy, data}, 8'h00);
    check("mid_rst_ready", 8'(cmd_ready), 8'h0);
    exp_q.delete();
    tick();
    tick();
    restart = 1'b0;
    lp0 = load_pulses;
    np0 = not_pulses;
    repeat (20) tick();
    check("flush_loads", 8'(load_pulses - lp0), 8'h0);
    check("flush_nots", 8'(not_pulses - np0), 8'h0);
    check("flush_busy", 8'(busy), 8'h0);
    check("flush_ready", 8'(cmd_ready), 8'h1);

    // Wrap-around: LOAD 0..9 back to back
    load_data_q.delete();
    load_cyc_q.delete();
    for (int i = 0; i < 10; i++) send(2'd0, 4'(i));
    drain();
    check("wrap_count", 8'(load_data_q.size()), 8'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < load_data_q.size()) check("wrap_data", 8'(load_data_q[i]), 8'(i));
      if (i > 0 && i < load_cyc_q.size())
        check("wrap_period", 8'(load_cyc_q[i] - load_cyc_q[i-1]), 8'd5);
    end

    // Random commands with random result backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_ready = 1'b0;
    res_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pro3_cmd_sequencer.md
Name: pro3_cmd_sequencer

Overview:
- Command sequencer for the Pro_3 data-register datapath.
- Accepts queued commands from a requester over a valid/ready handshake and buffers them in a small FIFO.
- Replays each command as LOAD/NOT strobes plus a DATA nibble to the datapath, waits a settle interval, then samples DO and returns it over a valid/ready result port.
- Sits between the test/control logic and the Pro_3 datapath and is the only driver of its LOAD, NOT and DATA inputs.

Parameters:
- DEPTH, 4, command FIFO depth in entries; power of two, minimum 2.
- SETTLE, 2, idle cycles after each strobe before DO is sampled; minimum 1.

Ports:
- clka  in  1  single system clock, rising edge.
- RESTART  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  requester presents a command.
- CMD_READY  out  1  FIFO can accept; equals not-full and not RESTART.
- CMD_OP  in  2  00 LOAD, 01 NOT, 10 LOAD_NOT, 11 READ.
- CMD_DATA  in  4  nibble loaded by LOAD and LOAD_NOT; ignored otherwise.
- LOAD  out  1  one-cycle load strobe to datapath.
- NOT  out  1  one-cycle invert strobe to datapath.
- DATA  out  4  data nibble to datapath; valid while LOAD is high, holds last value otherwise.
- DO  in  4  datapath output.
- RES_VALID  out  1  result available.
- RES_READY  in  1  consumer accepts result.
- RES_DATA  out  4  sampled DO.
- BUSY  out  1  FSM not in IDLE, or FIFO not empty.

Behaviour:
- Reset (async, RESTART=1):
  - FIFO pointers and count go to 0; FSM goes to IDLE.
  - LOAD, NOT, DATA, RES_VALID, RES_DATA and BUSY all go to 0.
  - Reset mid-operation aborts the command and flushes all FIFO contents; no strobe appears after reset asserts.
- FIFO:
  - A push occurs on each edge where CMD_VALID and CMD_READY are both high.
  - A pop occurs only when the FSM leaves IDLE. There is no bypass: a command pushed at edge E cannot be popped before E+1.
  - Push and pop on the same edge keep the count unchanged. When full, CMD_READY is 0 and nothing is lost.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, STROBE, SETTLE_W, STROBE2, SETTLE_W2, RESULT.
  - IDLE: if the FIFO is not empty, pop the head into registers op/dat and go to STROBE.
  - STROBE (1 cycle):
    - LOAD and LOAD_NOT drive LOAD=1 with DATA=dat.
    - NOT drives NOT=1.
    - READ drives no strobe.
    - Next state is SETTLE_W with the counter set to SETTLE.
  - SETTLE_W: strobes low; decrement the counter; when it reaches 0, go to STROBE2 if op=LOAD_NOT, else RESULT.
  - STROBE2 (LOAD_NOT only, 1 cycle): NOT=1, then SETTLE_W2 for SETTLE cycles, then RESULT.
  - RESULT:
    - On entry, register RES_DATA<=DO and RES_VALID<=1.
    - Hold both until RES_READY is high at an edge, then clear RES_VALID and go to IDLE.
    - RES_DATA keeps its value after the handshake.
  - LOAD and NOT are never high in the same cycle, and never high outside STROBE/STROBE2.
- Latency, LOAD command accepted at edge E0, SETTLE=2:
  - LOAD high from E1 to E2.
  - Settle over E2 to E4.
  - RES_VALID rises at E4.
  - The next command's strobe occurs no earlier than one cycle after the result handshake.
- RES_READY held high continuously: back-to-back commands complete every 2+SETTLE+1 cycles (LOAD_NOT: 3+2*SETTLE+1).
- BUSY goes to 0 only when the FSM is in IDLE and the FIFO count is 0.

Test Plan:
- Reset, then push LOAD 4'hA at E0 with RES_READY=1 -> LOAD=1 and DATA=A during E1 only; RES_VALID=1 at E4 with RES_DATA=DO=A; BUSY=0 after E5.
- Datapath holds A; push NOT -> a single NOT pulse, no LOAD pulse; RES_DATA=4'h5.
- Push LOAD_NOT 4'h3 -> LOAD pulse with DATA=3, then 2 idle cycles, then a NOT pulse; RES_DATA=4'hC; LOAD and NOT never overlap.
- RES_READY=0, push 5 commands back-to-back -> first pops; 4 accepted into FIFO; CMD_READY drops after FIFO is full; assert RES_READY -> all five results returned in order, none dropped.
- Assert RESTART during SETTLE_W with 3 queued commands -> outputs go to 0 immediately; after release, no strobes occur, BUSY=0, CMD_READY=1.
- Simultaneous push and pop with FIFO holding 1 entry -> count stays at 1; wrap-around over 10 commands preserves ordering (DATA sequence 0..9).
